// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared state type, round count and round-constant helper for the AES sequencer
package aes_seq_pkg;

    localparam int AES128_NR = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_HOLD  = 3'd4
    } aes_seq_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // rcon for round r is x^(r-1) in GF(2^8); round 0 means "no key step"
    function automatic logic [7:0] rcon_f(input logic [31:0] round);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 2; i <= 15; i++) begin
            if (32'(i) <= round) rc = xtime(rc);
        end
        return (round == 32'd0) ? 8'h00 : rc;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// rtl/aes_round_counter.sv - saturating round counter with clear/load-one/increment and last-round flag
module aes_round_counter #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          inc,
    output logic [RW-1:0] count_next,
    output logic          last
);

    localparam logic [RW-1:0] CNT_MAX  = RW'(NR);
    localparam logic [RW-1:0] CNT_LAST = RW'(NR - 1);

    logic [RW-1:0] count_q;
    logic [RW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (load)
            count_d = RW'(1);
        else if (inc && (count_q != CNT_MAX))
            count_d = count_q + RW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_next = count_d;
    assign last       = (count_q == CNT_LAST);

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - control FSM for the iterative AES cipher datapath and key expansion
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NR           = AES128_NR,
    parameter int RW           = 4,
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          dp_load,
    output logic          dp_round_en,
    output logic          dp_final,
    output logic          kexp_load,
    output logic          kexp_en,
    output logic [7:0]    rcon,
    output logic [RW-1:0] round_idx,
    output logic          busy
);

    if (NR < 2 || NR > 14 || (1 << RW) <= NR) begin : g_bad_cfg
        $error("aes_round_sequencer: NR must be 2..14 and fit in RW bits");
    end

    aes_seq_state_t state_q, state_d;

    logic          cnt_clr, cnt_load, cnt_inc;
    logic [RW-1:0] cnt_d;
    logic          cnt_last;

    logic          start_ready_c, start_fire;

    logic          dp_load_q, dp_load_d;
    logic          dp_round_en_q, dp_round_en_d;
    logic          dp_final_q, dp_final_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [RW-1:0] round_idx_q, round_idx_d;
    logic [7:0]    rcon_q, rcon_d;

    aes_round_counter #(.NR(NR), .RW(RW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .count_next (cnt_d),
        .last       (cnt_last)
    );

    // In HOLD, out_ready alone completes the transfer because out_valid is high there.
    always_comb begin
        start_ready_c = !rst && !abort &&
                        ((state_q == S_IDLE) ||
                         (BACK_TO_BACK && (state_q == S_HOLD) && out_ready));
        start_fire    = start_valid && start_ready_c;

        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_fire) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    state_d  = S_ROUND;
                    cnt_load = 1'b1;
                end
            end
            S_ROUND: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_last) state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (start_fire) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                end else if (abort || out_ready) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_comb begin
        dp_load_d     = (state_d == S_LOAD);
        dp_round_en_d = (state_d == S_ROUND) || (state_d == S_FINAL);
        dp_final_d    = (state_d == S_FINAL);
        out_valid_d   = (state_d == S_HOLD);
        busy_d        = (state_d == S_LOAD) || (state_d == S_ROUND) || (state_d == S_FINAL);
        round_idx_d   = '0;
        if (state_d == S_ROUND)
            round_idx_d = cnt_d;
        else if (state_d == S_FINAL)
            round_idx_d = RW'(NR);
        rcon_d = rcon_f(32'(round_idx_d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dp_load_q     <= 1'b0;
            dp_round_en_q <= 1'b0;
            dp_final_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            round_idx_q   <= '0;
            rcon_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            dp_load_q     <= dp_load_d;
            dp_round_en_q <= dp_round_en_d;
            dp_final_q    <= dp_final_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            round_idx_q   <= round_idx_d;
            rcon_q        <= rcon_d;
        end
    end

    assign start_ready = start_ready_c;
    assign out_valid   = out_valid_q;
    assign dp_load     = dp_load_q;
    assign kexp_load   = dp_load_q;
    assign dp_round_en = dp_round_en_q;
    assign kexp_en     = dp_round_en_q;
    assign dp_final    = dp_final_q;
    assign round_idx   = round_idx_q;
    assign rcon        = rcon_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer with a cycle-position model
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int RW = 4;
    localparam logic [7:0] RCON_TAB [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid, abort, out_ready;
    logic          start_ready, out_valid;
    logic          dp_load, dp_round_en, dp_final, kexp_load, kexp_en, busy;
    logic [7:0]    rcon;
    logic [RW-1:0] round_idx;

    aes_round_sequencer #(.NR(NR), .RW(RW), .BACK_TO_BACK(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .kexp_load   (kexp_load),
        .kexp_en     (kexp_en),
        .rcon        (rcon),
        .round_idx   (round_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // pos = cycles since the block was accepted: 0 none, 1 load, 2..NR+1 rounds, >=NR+2 result held
    int pos = 0;

    always @(posedge clk or posedge rst) begin
        if (rst)
            pos <= 0;
        else if (pos == 0)
            pos <= (start_valid && !abort) ? 1 : 0;
        else if (abort)
            pos <= 0;
        else if (pos >= NR + 2)
            pos <= out_ready ? (start_valid ? 1 : 0) : pos;
        else
            pos <= pos + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int hs_cyc = 0, load_rel = -1, r1_rel = -1, last_round_rel = -1, last_round_idx = -1;
    int final_rel = -1, final_idx = -1, first_ov_rel = -1;
    int xfers = 0, ov_cycles = 0, n_loads = 0;
    int load_cyc [$];
    logic [7:0] final_rcon = 8'h00;
    logic ov_prev = 1'b0;

    always @(negedge clk) begin : cmp
        int  idx;
        bit  in_rounds;
        in_rounds = (pos >= 2) && (pos <= NR + 1);
        idx = in_rounds ? pos - 1 : 0;
        chk("start_ready", start_ready,
            !rst && !abort && ((pos == 0) || ((pos >= NR + 2) && out_ready)));
        chk("out_valid", out_valid, pos >= NR + 2);
        chk("dp_load", dp_load, pos == 1);
        chk("kexp_load", kexp_load, pos == 1);
        chk("dp_round_en", dp_round_en, in_rounds);
        chk("kexp_en", kexp_en, in_rounds);
        chk("dp_final", dp_final, pos == NR + 1);
        chk("round_idx", round_idx, idx);
        chk("rcon", rcon, RCON_TAB[idx]);
        chk("busy", busy, (pos >= 1) && (pos <= NR + 1));

        if (start_valid && start_ready) hs_cyc <= cyc;
        if (dp_load) begin
            load_rel <= cyc - hs_cyc;
            load_cyc.push_back(cyc);
            n_loads <= n_loads + 1;
        end
        if (dp_round_en && round_idx == 4'd1) r1_rel <= cyc - hs_cyc;
        if (dp_round_en && !dp_final) begin
            last_round_rel <= cyc - hs_cyc;
            last_round_idx <= int'(round_idx);
        end
        if (dp_final) begin
            final_rel  <= cyc - hs_cyc;
            final_idx  <= int'(round_idx);
            final_rcon <= rcon;
        end
        if (out_valid && !ov_prev) first_ov_rel <= cyc - hs_cyc;
        if (out_valid) ov_cycles <= ov_cycles + 1;
        if (out_valid && out_ready) xfers <= xfers + 1;
        ov_prev <= out_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start_valid = 1'b1;
        tick(1);
        start_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int x0, l0, o0;
        bool_found: begin end
        rst = 1'b1; start_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        tick(3);
        chk("reset start_ready", start_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        rst = 1'b0;
        tick(2);

        // single block, consumer always ready
        out_ready = 1'b1;
        x0 = xfers;
        start_pulse();
        tick(14);
        chk("t1 load_rel", load_rel, 1);
        chk("t1 round1_rel", r1_rel, 2);
        chk("t1 last_round_rel", last_round_rel, 10);
        chk("t1 last_round_idx", last_round_idx, 9);
        chk("t1 final_rel", final_rel, 11);
        chk("t1 final_idx", final_idx, 10);
        chk("t1 final_rcon", final_rcon, 8'h36);
        chk("t1 first_ov_rel", first_ov_rel, 12);
        chk("t1 xfers", xfers - x0, 1);

        // backpressure for 20 cycles
        out_ready = 1'b0;
        x0 = xfers;
        start_pulse();
        tick(11);
        l0 = n_loads;
        tick(20);
        chk("t2 held out_valid", out_valid, 1);
        chk("t2 no extra load", n_loads - l0, 0);
        chk("t2 no xfer yet", xfers - x0, 0);
        out_ready = 1'b1;
        tick(2);
        chk("t2 one xfer", xfers - x0, 1);
        chk("t2 idle start_ready", start_ready, 1);

        // back-to-back with start held high
        l0 = load_cyc.size();
        start_valid = 1'b1;
        tick(40);
        start_valid = 1'b0;
        tick(14);
        chk("t3 loads", load_cyc.size() - l0, 4);
        for (int i = l0 + 1; i < load_cyc.size(); i++)
            chk("t3 load spacing", load_cyc[i] - load_cyc[i-1], 12);

        // abort at round 5
        start_pulse();
        for (int i = 0; i < 20 && round_idx != 4'd5; i++) tick(1);
        chk("t4 reached round5", round_idx, 5);
        o0 = ov_cycles;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4 busy after abort", busy, 0);
        chk("t4 round_idx after abort", round_idx, 0);
        tick(15);
        chk("t4 no out_valid", ov_cycles - o0, 0);
        start_pulse();
        tick(14);
        chk("t4 restart first_ov_rel", first_ov_rel, 12);
        chk("t4 restart load_rel", load_rel, 1);

        // abort together with start_valid in IDLE
        l0 = n_loads;
        abort = 1'b1; start_valid = 1'b1;
        #1;
        chk("t5 start_ready under abort", start_ready, 0);
        tick(3);
        abort = 1'b0; start_valid = 1'b0;
        chk("t5 no load", n_loads - l0, 0);
        chk("t5 busy", busy, 0);

        // abort in HOLD while the consumer takes the result
        out_ready = 1'b0;
        start_pulse();
        for (int i = 0; i < 20 && !out_valid; i++) tick(1);
        chk("t5b in hold", out_valid, 1);
        x0 = xfers;
        abort = 1'b1; out_ready = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t5b xfer", xfers - x0, 1);
        chk("t5b out_valid dropped", out_valid, 0);
        tick(2);

        // async reset in the middle of a round
        start_pulse();
        tick(4);
        #2 rst = 1'b1;
        #1;
        chk("t6 rst dp_round_en", dp_round_en, 0);
        chk("t6 rst round_idx", round_idx, 0);
        chk("t6 rst rcon", rcon, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst start_ready", start_ready, 0);
        tick(2);
        rst = 1'b0;
        #1;
        chk("t6 start_ready after release", start_ready, 1);
        start_pulse();
        tick(14);
        chk("t6 fresh first_ov_rel", first_ov_rel, 12);
        chk("t6 fresh final_rcon", final_rcon, 8'h36);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
